// File: rtl/vm_pkg.sv
// Purpose: shared coin codes, coin value decode and FSM state type for vending_machine_mc.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VEND,
        ST_CHANGE
    } vm_state_t;

    // Face value of a coin code in coin units.
    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return 3'd1;
            COIN_2:  return 3'd2;
            COIN_5:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_change_gen.sv
// Purpose: greedy change selector, picks the largest coin not exceeding the remaining credit.
// Latency: combinational, zero cycles.
// Backpressure: none; the owner subtracts value once per cycle.
// Ports: credit (remaining credit) -> code (coin code, COIN_NONE when credit is 0), value (its units).
module vm_change_gen
    import vm_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          code,
    output logic [CREDIT_W-1:0] value
);

    always_comb begin
        code = COIN_NONE;
        if (credit >= CREDIT_W'(5)) begin
            code = COIN_5;
        end else if (credit >= CREDIT_W'(2)) begin
            code = COIN_2;
        end else if (credit != '0) begin
            code = COIN_1;
        end
        value = CREDIT_W'(coin_value(code));
    end

endmodule

// File: rtl/vending_machine_mc.sv
// Purpose: multi-product vending controller: select, collect coins, vend pulse, greedy change return.
// Latency: done one cycle after the coin that covers the price; change coins follow one per cycle.
// Backpressure: none; coins arriving outside COLLECT are bounced via coin_reject one cycle later.
// Ports: clk, rst (async active-low), start/choice (IDLE only), coins, cancel (VM_CANCEL_EN only)
//        -> done/product (vend pulse), change (returned coin), coin_reject, busy, credit.
// Build option: define VM_CANCEL_EN to add the cancel input and refund path.
module vending_machine_mc
    import vm_pkg::*;
#(
    parameter int                                NUM_PRODUCTS = 4,
    parameter int                                CREDIT_W     = 8,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0]  PRICE_LIST   = {8'd7, 8'd5, 8'd3, 8'd2},
    localparam int                               SEL_W        = $clog2(NUM_PRODUCTS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SEL_W-1:0]    choice,
    input  logic [1:0]          coins,
`ifdef VM_CANCEL_EN
    input  logic                cancel,
`endif
    output logic                done,
    output logic [SEL_W-1:0]    product,
    output logic [1:0]          change,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    vm_state_t           state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CREDIT_W-1:0] price_q, price_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;

    logic                coin_vld;
    logic                choice_ok;
    logic [CREDIT_W-1:0] coin_credit;
    logic [1:0]          chg_code;
    logic [CREDIT_W-1:0] chg_value;

    assign coin_vld    = (coins != COIN_NONE);
    assign choice_ok   = (32'(choice) < NUM_PRODUCTS);
    assign coin_credit = credit_q + CREDIT_W'(coin_value(coins));

    vm_change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change_gen (
        .credit (credit_q),
        .code   (chg_code),
        .value  (chg_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            price_q  <= '0;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            price_q  <= price_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        price_d  = price_q;
        credit_d = credit_q;
        reject_d = 1'b0;

        done     = (state_q == ST_VEND);
        product  = (state_q == ST_VEND) ? sel_q : '0;
        change   = (state_q == ST_CHANGE) ? chg_code : COIN_NONE;
        busy     = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                reject_d = coin_vld;
                if (start && choice_ok) begin
                    sel_d    = choice;
                    price_d  = PRICE_LIST[int'(choice)*CREDIT_W +: CREDIT_W];
                    credit_d = '0;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
`ifdef VM_CANCEL_EN
                // Cancel takes priority: any coin in the same cycle is bounced.
                if (cancel) begin
                    reject_d = coin_vld;
                    state_d  = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end else
`endif
                if (coin_vld) begin
                    credit_d = coin_credit;
                    if (coin_credit >= price_q) begin
                        state_d = ST_VEND;
                    end
                end
            end
            ST_VEND: begin
                reject_d = coin_vld;
                credit_d = credit_q - price_q;
                state_d  = (credit_q != price_q) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                reject_d = coin_vld;
                credit_d = credit_q - chg_value;
                if (credit_q == chg_value) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign coin_reject = reject_q;
    assign credit      = credit_q;

endmodule

// File: doc/vending_machine_mc.md
# vending_machine_mc

- Parametrised multi-product vending controller, successor to the two-product `vending_machine`.
- Accepts a product select and a coin stream, and tracks credit against a per-product price table.
- Pulses `done` with the vended product index, then returns change one coin per cycle, largest first.
- Sits between the coin-acceptor decoder and the dispenser/change-hopper drivers.

## Interface
Parameters:
- `NUM_PRODUCTS`, 4: number of selectable products (≥2)
- `CREDIT_W`, 8: credit/price width; must hold max price + 4
- `PRICE_LIST`, {8'd7,8'd5,8'd3,8'd2}: packed `NUM_PRODUCTS*CREDIT_W` prices in coin units; product 0 occupies the LSBs; every price must be ≥1
- `SEL_W` (localparam): `$clog2(NUM_PRODUCTS)`

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin transaction (sampled in IDLE only)
- `choice`  in  SEL_W  product select, sampled with `start`
- `coins`  in  2  coin code: 00 none, 01 = 1 unit, 10 = 2 units, 11 = 5 units
- `cancel`  in  1  abort and refund (present only with `VM_CANCEL_EN`)
- `done`  out  1  one-cycle vend pulse
- `product`  out  SEL_W  vended index, valid while `done`=1, otherwise 0
- `change`  out  2  coin being returned this cycle, same coding as `coins`; 00 = none
- `coin_reject`  out  1  offered coin not credited (returned to the user)
- `busy`  out  1  state ≠ IDLE
- `credit`  out  CREDIT_W  current credit register

## Operation
- States: IDLE, COLLECT, VEND, CHANGE.
- IDLE
  - On `start`=1 with `choice` < `NUM_PRODUCTS`: latch `sel_q`=`choice` and `price_q`=PRICE_LIST[choice], clear credit, go to COLLECT.
  - An out-of-range `choice` is ignored; the block stays in IDLE.
  - Coins offered in IDLE are rejected.
- COLLECT
  - For `coins`≠00, next_credit = credit + value(coins).
  - If next_credit ≥ `price_q`, go to VEND with credit = next_credit; otherwise stay in COLLECT.
  - `start` is ignored while in COLLECT.
- VEND (exactly 1 cycle)
  - `done`=1, `product`=`sel_q`.
  - credit ← credit − `price_q`.
  - Go to CHANGE if the remainder is >0, else to IDLE.
- CHANGE
  - Each cycle, drive `change` with the largest coin whose value ≤ credit, and subtract that value.
  - Go to IDLE in the cycle credit reaches 0.
- Coins offered in VEND or CHANGE are rejected and not credited.
- Outputs
  - `done`, `product` and `change` are Moore outputs decoded from state and registers.
  - `coin_reject` is registered: it is high in the cycle after the rejected coin was sampled.
- Arithmetic: unsigned, `CREDIT_W` bits; no overflow is possible given the `CREDIT_W` constraint.
- Reset: asynchronous assertion from any state, mid-transaction included.
  - Credit is discarded, state goes to IDLE.
  - All outputs reset to 0: `done`, `product`, `change`, `coin_reject`, `busy`, `credit`.

## Timing
- `start` sampled at edge 0 → COLLECT from cycle 1.
- Final coin sampled at edge k → VEND in cycle k+1 (`done` high) → first change coin in cycle k+2.
- Change of value R occupies ⌈greedy coin count⌉ cycles, then IDLE; `busy` falls the cycle after the last change coin.
- A new `start` is accepted in the first IDLE cycle.
- A coin and `cancel` in the same COLLECT cycle: cancel wins and the coin is rejected.

## Configuration
Macro `VM_CANCEL_EN`:
- Defined:
  - `cancel` port exists.
  - `cancel`=1 in COLLECT → go to CHANGE with the full credit as refund. No `done` is issued.
  - If credit=0, go straight to IDLE.
  - `cancel` is ignored in all other states.
- Undefined:
  - The port is absent and no refund path exists.
  - A transaction completes only by vending.

## Structure
- Package `vm_pkg`:
  - coin code constants (`COIN_NONE`, `COIN_1`, `COIN_2`, `COIN_5`)
  - `coin_value` function
  - state enum `vm_state_t`
- Sub-module `vm_change_gen`: combinational greedy selector. Input is the remaining credit; outputs are the coin code and its value.

## Test plan
1. Start with choice=1 (price 3); coins 01, 10 → `done` with product=1 in the cycle after the 10 coin; `change` stays 00; back to IDLE.
2. Choice=3 (price 7); coins 11, 11 → credit 10, `done`; `change` 10 then 01; `busy` low the next cycle.
3. Choice=0 (price 2); coin 11 → `done`, then `change` 10, 01 (remainder 3); a coin 01 offered during CHANGE → `coin_reject`=1 one cycle later and credit unaffected.
4. `VM_CANCEL_EN`: choice=2; coins 10, 01 (credit 3), then `cancel` with simultaneous coin 10 → `coin_reject`; `change` 10, 01; `done` never asserted.
5. Start with an out-of-range `choice` (NUM_PRODUCTS=3, choice=3) → stays IDLE, `busy`=0; coins are rejected.
6. Drive `rst` low during CHANGE with remainder 4 → all outputs 0 immediately; after release, a new transaction with choice=1 vends normally.
